module_seg_scan: RTL

MODULE_SEG_SCAN -- requirements
Module: module_seg_scan

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_scan_timer.sv | 38 +++
 rtl/module_seg_scan.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment pattern type, blank/dash constants and BCD to segment decode
package seg_pkg;

    // Bit order is {g,f,e,d,c,b,a}, active-high form.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_DASH  = 7'b1000000;

    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - refresh divider and digit scan index with a wrap pulse
module seg_scan_timer #(
    parameter int REFRESH_DIV = 50000,
    parameter int N_DIGITS    = 4,
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx,
    output logic          wrap
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/module_seg_scan.sv
// rtl/module_seg_scan.sv - multiplexed 7-segment BCD display scanner with registered outputs
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module module_seg_scan
    import seg_pkg::*;
#(
    parameter int N_DIGITS         = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int SEG_ACTIVE_LOW   = 0,
    parameter int TRANS_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_input,
    input  logic                  listo,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   transis,
    output logic                  loaded
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // The off level doubles as the polarity mask applied to lit patterns.
    localparam seg_t                SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7f : SEG_BLANK;
    localparam logic [N_DIGITS-1:0] TRANS_OFF = (TRANS_ACTIVE_LOW != 0) ? '1 : '0;

    logic [IW-1:0]         idx;
    logic                  wrap;
    logic [4*N_DIGITS-1:0] latch_q, latch_d;
    logic                  loaded_q, loaded_d;
    seg_t                  seg_q, seg_d;
    logic [N_DIGITS-1:0]   transis_q, transis_d;
    logic [3:0]            digit;
    logic [N_DIGITS-1:0]   onehot;
    logic [N_DIGITS-1:0]   blank;
    logic                  cur_blank;

    seg_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .N_DIGITS    (N_DIGITS)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .idx  (idx),
        .wrap (wrap)
    );

    always_comb begin
        latch_d  = listo ? digits_input : latch_q;
        loaded_d = loaded_q | listo;
    end

    always_comb begin
        digit  = 4'd0;
        onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                digit     = latch_q[4*k +: 4];
                onehot[k] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nonzero_above;

    // Walk from the most significant digit down; a slot is blank while no nonzero digit has been seen.
    always_comb begin
        blank         = '0;
        nonzero_above = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            nonzero_above = nonzero_above | (latch_q[4*k +: 4] != 4'd0);
            blank[k]      = ~nonzero_above;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    always_comb begin
        cur_blank = |(blank & onehot);
        seg_d     = cur_blank ? SEG_OFF : (bcd_to_seg(digit) ^ SEG_OFF);
        transis_d = cur_blank ? TRANS_OFF : (onehot ^ TRANS_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q   <= '0;
            loaded_q  <= 1'b0;
            seg_q     <= SEG_OFF;
            transis_q <= TRANS_OFF;
        end else begin
            latch_q   <= latch_d;
            loaded_q  <= loaded_d;
            seg_q     <= seg_d;
            transis_q <= transis_d;
        end
    end

    // The scan index may only move on the cycle after a wrap pulse.
    assert property (@(posedge clk) disable iff (rst) !wrap |=> $stable(idx));

    assign seg     = seg_q;
    assign transis = transis_q;
    assign loaded  = loaded_q;

endmodule
